// File: rtl/helios_stream_arbiter.sv
// Round-robin job arbiter that shares one byte-stream decoder core among NUM_CH clients.
// Whole jobs (IN_BYTES in, OUT_BYTES out) are granted; a watchdog flags a stalled core response.
module helios_stream_arbiter_lane (
    input  logic sel,
    input  logic in_phase,
    input  logic out_phase,
    input  logic core_in_ready,
    input  logic core_out_valid,
    output logic ch_in_ready,
    output logic ch_out_valid
);
    assign ch_in_ready  = sel & in_phase  & core_in_ready;
    assign ch_out_valid = sel & out_phase & core_out_valid;
endmodule

module helios_stream_arbiter #(
    parameter  int NUM_CH         = 4,
    parameter  int IN_BYTES       = 4,
    parameter  int OUT_BYTES      = 2,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int CH_W           = $clog2(NUM_CH),
    localparam int CNT_W          = $clog2(((IN_BYTES > OUT_BYTES) ? IN_BYTES : OUT_BYTES) + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8*NUM_CH-1:0]  ch_in_data,
    input  logic [NUM_CH-1:0]    ch_in_valid,
    output logic [NUM_CH-1:0]    ch_in_ready,
    output logic [7:0]           ch_out_data,
    output logic [NUM_CH-1:0]    ch_out_valid,
    input  logic [NUM_CH-1:0]    ch_out_ready,
    output logic [7:0]           core_in_data,
    output logic                 core_in_valid,
    input  logic                 core_in_ready,
    input  logic [7:0]           core_out_data,
    input  logic                 core_out_valid,
    output logic                 core_out_ready,
    output logic [CH_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_BYTES - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_BYTES - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_INPUT, S_OUTPUT} state_t;

    state_t           state, state_nx;
    logic [CH_W-1:0]  last_grant, arb_id, cand;
    logic             arb_hit, in_xfer, out_xfer;
    logic [CNT_W-1:0] in_cnt, out_cnt;
    logic [WD_W-1:0]  wd_cnt;

    // First requester strictly after last_grant, wrapping modulo NUM_CH.
    always_comb begin
        arb_hit = 1'b0;
        arb_id  = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(last_grant) + k) % NUM_CH);
            if (!arb_hit && ch_in_valid[cand]) begin
                arb_hit = 1'b1;
                arb_id  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (arb_hit) state_nx = S_INPUT;
            S_INPUT:  if (in_xfer && in_cnt == IN_LAST) state_nx = S_OUTPUT;
            S_OUTPUT: if (out_xfer && out_cnt == OUT_LAST) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        core_in_data   = ch_in_data[{grant_id, 3'b000} +: 8];
        core_in_valid  = (state == S_INPUT) & ch_in_valid[grant_id];
        core_out_ready = (state == S_OUTPUT) & ch_out_ready[grant_id];
        in_xfer        = core_in_valid & core_in_ready;
        out_xfer       = core_out_ready & core_out_valid;
    end

    assign ch_out_data = core_out_data;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        helios_stream_arbiter_lane u_lane (
            .sel           (grant_id == CH_W'(i)),
            .in_phase      (state == S_INPUT),
            .out_phase     (state == S_OUTPUT),
            .core_in_ready (core_in_ready),
            .core_out_valid(core_out_valid),
            .ch_in_ready   (ch_in_ready[i]),
            .ch_out_valid  (ch_out_valid[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_id    <= '0;
            last_grant  <= CH_W'(NUM_CH - 1);
            in_cnt      <= '0;
            out_cnt     <= '0;
            wd_cnt      <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            busy <= (state_nx != S_IDLE);
            if (state == S_IDLE && arb_hit) grant_id <= arb_id;
            if (in_xfer) in_cnt <= (in_cnt == IN_LAST) ? '0 : in_cnt + 1'b1;
            if (out_xfer) begin
                if (out_cnt == OUT_LAST) begin
                    out_cnt    <= '0;
                    last_grant <= grant_id;
                end else begin
                    out_cnt <= out_cnt + 1'b1;
                end
            end
            // Watchdog only observes; the job keeps running after a timeout.
            if (state == S_OUTPUT && !core_out_valid) begin
                if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == WD_LAST) timeout_err <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_helios_stream_arbiter.sv
// Directed bench for helios_stream_arbiter: single job, round-robin, no-preempt,
// backpressure, watchdog and async reset mid-job.
module tb_helios_stream_arbiter;
    localparam int NCH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [8*NCH-1:0] ch_in_data = '0;
    logic [NCH-1:0]   ch_in_valid = '0;
    logic [NCH-1:0]   ch_in_ready;
    logic [7:0]       ch_out_data;
    logic [NCH-1:0]   ch_out_valid;
    logic [NCH-1:0]   ch_out_ready = '0;
    logic [7:0]       core_in_data;
    logic             core_in_valid;
    logic             core_in_ready = 1'b0;
    logic [7:0]       core_out_data = '0;
    logic             core_out_valid = 1'b0;
    logic             core_out_ready;
    logic [1:0]       grant_id;
    logic             busy;
    logic             timeout_err;

    int checks = 0;
    int failures = 0;

    helios_stream_arbiter #(
        .NUM_CH(NCH), .IN_BYTES(4), .OUT_BYTES(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .ch_in_data(ch_in_data), .ch_in_valid(ch_in_valid), .ch_in_ready(ch_in_ready),
        .ch_out_data(ch_out_data), .ch_out_valid(ch_out_valid), .ch_out_ready(ch_out_ready),
        .core_in_data(core_in_data), .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
        .core_out_data(core_out_data), .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ch_in_valid = '0; ch_out_ready = '0; core_in_ready = 1'b0; core_out_valid = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        tick();
        reset = 1'b1;
    endtask

    task automatic arb(input logic [3:0] mask, input int g);
        ch_in_valid = mask;
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_in_ready", 32'(ch_in_ready), 32'd0);
        tick();
        chk("grant", 32'(grant_id), 32'(g));
        chk("grant_busy", 32'(busy), 32'd1);
    endtask

    task automatic in_byte(input int g, input int idx, input logic [3:0] exp_rdy);
        for (int i = 0; i < NCH; i++) ch_in_data[8*i +: 8] = 8'((i + 1) * 16 + idx + 1);
        core_in_ready = 1'b1;
        #1;
        chk("in_data", 32'(core_in_data), 32'((g + 1) * 16 + idx + 1));
        chk("in_valid", 32'(core_in_valid), 32'd1);
        chk("in_ready", 32'(ch_in_ready), 32'(exp_rdy));
        tick();
    endtask

    task automatic out_byte(input int g, input int idx);
        core_out_valid = 1'b1;
        core_out_data = 8'(8'hA1 + idx);
        ch_out_ready = '1;
        core_in_ready = 1'b1;
        #1;
        chk("out_valid", 32'(ch_out_valid), 32'(4'b0001 << g));
        chk("out_data", 32'(ch_out_data), 32'(8'hA1 + idx));
        chk("core_out_ready", 32'(core_out_ready), 32'd1);
        chk("out_in_ready", 32'(ch_in_ready), 32'd0);
        tick();
        core_out_valid = 1'b0;
    endtask

    task automatic job(input logic [3:0] mask, input int g);
        arb(mask, g);
        for (int b = 0; b < 4; b++) in_byte(g, b, 4'(4'b0001 << g));
        out_byte(g, 0);
        out_byte(g, 1);
        chk("job_done_busy", 32'(busy), 32'd0);
        chk("job_done_grant", 32'(grant_id), 32'(g));
        chk("job_done_out_valid", 32'(ch_out_valid), 32'd0);
    endtask

    initial begin
        int sent;
        int rcv;
        tick();
        tick();
        chk("por_busy", 32'(busy), 32'd0);
        chk("por_grant", 32'(grant_id), 32'd0);
        chk("por_core_in_valid", 32'(core_in_valid), 32'd0);
        chk("por_core_out_ready", 32'(core_out_ready), 32'd0);
        chk("por_tmo", 32'(timeout_err), 32'd0);
        reset = 1'b1;

        // single job on channel 0
        job(4'b0001, 0);
        ch_in_valid = '0;
        tick();
        chk("hold_grant", 32'(grant_id), 32'd0);

        // all request: 0,1,2,3 then wrap to 0
        do_reset();
        job(4'b1111, 0);
        job(4'b1111, 1);
        job(4'b1111, 2);
        job(4'b1111, 3);
        job(4'b1111, 0);
        ch_in_valid = '0;
        tick();

        // ch0 arrives while ch2 is mid-input; no preemption, ch3 idle so next is 0
        arb(4'b0100, 2);
        in_byte(2, 0, 4'b0100);
        in_byte(2, 1, 4'b0100);
        ch_in_valid = 4'b0101;
        in_byte(2, 2, 4'b0100);
        in_byte(2, 3, 4'b0100);
        out_byte(2, 0);
        out_byte(2, 1);
        chk("np_busy", 32'(busy), 32'd0);
        job(4'b0101, 0);
        ch_in_valid = '0;
        tick();

        // ch1 job with toggling core_in_ready and ch_out_ready[1]
        arb(4'b0010, 1);
        sent = 0;
        for (int c = 0; c < 16 && sent < 4; c++) begin
            core_in_ready = (c % 2) == 1;
            ch_in_data[15:8] = 8'(8'h21 + sent);
            #1;
            chk("bp_in_data", 32'(core_in_data), 32'(8'h21 + sent));
            chk("bp_in_ready", 32'(ch_in_ready), (c % 2) == 1 ? 32'h2 : 32'h0);
            tick();
            if ((c % 2) == 1) sent++;
        end
        chk("bp_sent", 32'(sent), 32'd4);
        core_in_ready = 1'b1;
        #1;
        chk("bp_in_done", 32'(ch_in_ready), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        core_out_valid = 1'b1;
        rcv = 0;
        for (int c = 0; c < 8 && rcv < 2; c++) begin
            ch_out_ready = ((c % 2) == 1) ? 4'b0010 : 4'b0000;
            core_out_data = 8'(8'hA1 + rcv);
            #1;
            chk("bp_core_out_ready", 32'(core_out_ready), 32'((c % 2) == 1));
            chk("bp_out_valid", 32'(ch_out_valid), 32'h2);
            chk("bp_out_data", 32'(ch_out_data), 32'(8'hA1 + rcv));
            tick();
            if ((c % 2) == 1) rcv++;
        end
        core_out_valid = 1'b0;
        chk("bp_rcv", 32'(rcv), 32'd2);
        chk("bp_done_busy", 32'(busy), 32'd0);
        ch_in_valid = '0;
        ch_out_ready = '0;
        tick();

        // watchdog: core silent for 8 OUTPUT cycles
        arb(4'b0100, 2);
        for (int b = 0; b < 4; b++) in_byte(2, b, 4'b0100);
        ch_in_valid = '0;
        core_out_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("wd_tmo", 32'(timeout_err), 32'(k == 8));
        end
        chk("wd_busy", 32'(busy), 32'd1);
        out_byte(2, 0);
        out_byte(2, 1);
        chk("wd_sticky", 32'(timeout_err), 32'd1);
        chk("wd_done_busy", 32'(busy), 32'd0);
        tick();
        tick();
        chk("wd_sticky_idle", 32'(timeout_err), 32'd1);
        do_reset();

        // async reset during OUTPUT with out_cnt=1
        arb(4'b0010, 1);
        for (int b = 0; b < 4; b++) in_byte(1, b, 4'b0010);
        out_byte(1, 0);
        core_out_valid = 1'b1;
        ch_out_ready = '1;
        #1;
        chk("mid_out_valid", 32'(ch_out_valid), 32'h2);
        reset = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_out_valid", 32'(ch_out_valid), 32'd0);
        chk("async_core_out_ready", 32'(core_out_ready), 32'd0);
        chk("async_grant", 32'(grant_id), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        core_out_valid = 1'b0;
        ch_in_valid = '0;
        tick();
        arb(4'b1111, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
